// File: rtl/cv32e40p_rf_recovery_ctrl_if.sv
// Commit snoop, halt handshake and register-file replay bus
// for cv32e40p_rf_recovery_ctrl.
interface cv32e40p_rf_recovery_ctrl_if #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CAP_PORTS = 2,
    parameter int NUM_WPORTS    = 2
);
    logic [NUM_CAP_PORTS-1:0]            cap_we_i;
    logic [NUM_CAP_PORTS*ADDR_WIDTH-1:0] cap_waddr_i;
    logic [NUM_CAP_PORTS*DATA_WIDTH-1:0] cap_wdata_i;
    logic                                recover_req_i;
    logic                                core_halted_i;
    logic                                core_halt_o;
    logic                                recover_busy_o;
    logic                                recover_done_o;
    logic [NUM_WPORTS-1:0]               rf_we_o;
    logic [NUM_WPORTS*ADDR_WIDTH-1:0]    rf_waddr_o;
    logic [NUM_WPORTS*DATA_WIDTH-1:0]    rf_wdata_o;
    logic                                parity_err_o;

    modport slave (
        input  cap_we_i, cap_waddr_i, cap_wdata_i,
        input  recover_req_i, core_halted_i,
        output core_halt_o, recover_busy_o, recover_done_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, parity_err_o
    );

    modport master (
        output cap_we_i, cap_waddr_i, cap_wdata_i,
        output recover_req_i, core_halted_i,
        input  core_halt_o, recover_busy_o, recover_done_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, parity_err_o
    );
endinterface

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Shadow register file with halt-and-replay recovery into the core RF.
// Optional shadow parity: define CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl #(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CAP_PORTS = 2,
    parameter int NUM_WPORTS    = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    cv32e40p_rf_recovery_ctrl_if.slave bus
);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);
    localparam logic [PW-1:0] STEP = PW'(NUM_WPORTS);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_RESTORE, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PW-1:0]            r_ptr;
    logic [DATA_WIDTH-1:0]    r_shadow [NUM_REGS];
    logic [NUM_CAP_PORTS-1:0] w_cap_we;
    logic [PW-1:0]            w_idx;
    logic                     w_cap_en;
    logic                     w_last;
    logic                     w_halt;
    logic                     w_busy;
    logic                     w_done;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic                     r_par [NUM_REGS];
    logic                     r_perr;
    logic                     w_perr_hit;
`endif

    assign w_last = (r_ptr + STEP) > LAST;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_HALT)
                r_ptr <= PW'(1);
            else if (r_state == S_RESTORE)
                r_ptr <= r_ptr + STEP;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_en    = 1'b0;
        w_halt      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cap_en = 1'b1;
                if (bus.recover_req_i) w_state_nxt = S_HALT;
            end
            S_HALT: begin
                w_cap_en = 1'b1;
                w_halt   = 1'b1;
                w_busy   = 1'b1;
                if (bus.core_halted_i) w_state_nxt = S_RESTORE;
            end
            S_RESTORE: begin
                w_halt = 1'b1;
                w_busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_halt      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // x0 and out-of-range addresses never reach the shadow
    always_comb begin
        w_cap_we = '0;
        for (int k = 0; k < NUM_CAP_PORTS; k++)
            w_cap_we[k] = bus.cap_we_i[k]
                && (bus.cap_waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                && ({1'b0, bus.cap_waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]} <= LAST);
    end

    // Later ports overwrite earlier ones on an address collision
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                r_par[i]    <= 1'b0;
`endif
            end
        end else if (w_cap_en) begin
            for (int k = 0; k < NUM_CAP_PORTS; k++)
                if (w_cap_we[k]) begin
                    r_shadow[bus.cap_waddr_i[k*ADDR_WIDTH +: IW]] <=
                        bus.cap_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                    r_par[bus.cap_waddr_i[k*ADDR_WIDTH +: IW]] <=
                        ^bus.cap_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
`endif
                end
        end
    end

    always_comb begin
        bus.rf_we_o    = '0;
        bus.rf_waddr_o = '0;
        bus.rf_wdata_o = '0;
        w_idx          = '0;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        w_perr_hit     = 1'b0;
`endif
        for (int j = 0; j < NUM_WPORTS; j++) begin
            w_idx = r_ptr + PW'(j);
            if (r_state == S_RESTORE && w_idx <= LAST) begin
                bus.rf_we_o[j] = 1'b1;
                bus.rf_waddr_o[j*ADDR_WIDTH +: ADDR_WIDTH] = w_idx[ADDR_WIDTH-1:0];
                bus.rf_wdata_o[j*DATA_WIDTH +: DATA_WIDTH] = r_shadow[w_idx[IW-1:0]];
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                if ((^r_shadow[w_idx[IW-1:0]]) != r_par[w_idx[IW-1:0]])
                    w_perr_hit = 1'b1;
`endif
            end
        end
    end

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_perr <= 1'b0;
        else if (w_perr_hit)
            r_perr <= 1'b1;
    end

    assign bus.parity_err_o = r_perr | w_perr_hit;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.core_halt_o    = w_halt;
    assign bus.recover_busy_o = w_busy;
    assign bus.recover_done_o = w_done;
endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Randomised self-checking bench for cv32e40p_rf_recovery_ctrl:
// 32-reg/2-port and 64-reg/3-port instances against a shadow model.
module tb_cv32e40p_rf_recovery_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cv32e40p_rf_recovery_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32),
        .NUM_CAP_PORTS(2), .NUM_WPORTS(2)) bus ();
    cv32e40p_rf_recovery_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32),
        .NUM_CAP_PORTS(2), .NUM_WPORTS(3)) bus2 ();

    cv32e40p_rf_recovery_ctrl #(.NUM_REGS(32), .ADDR_WIDTH(6), .DATA_WIDTH(32),
        .NUM_CAP_PORTS(2), .NUM_WPORTS(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    cv32e40p_rf_recovery_ctrl #(.NUM_REGS(64), .ADDR_WIDTH(6), .DATA_WIDTH(32),
        .NUM_CAP_PORTS(2), .NUM_WPORTS(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m  [64];
    logic [31:0] m2 [64];
    bit          bad [64];
    bit          exp_perr;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_cap(input logic [1:0] we, input logic [5:0] a0,
        input logic [5:0] a1, input logic [31:0] d0, input logic [31:0] d1,
        input bit live);
        bus.cap_we_i    = we;
        bus.cap_waddr_i = {a1, a0};
        bus.cap_wdata_i = {d1, d0};
        if (live) begin
            if (we[0] && a0 != 0 && a0 < 32) begin m[a0] = d0; bad[a0] = 0; end
            if (we[1] && a1 != 0 && a1 < 32) begin m[a1] = d1; bad[a1] = 0; end
        end
    endtask

    task automatic rand_cap(input bit live);
        drive_cap(2'($urandom), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  $urandom, $urandom, live);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin m[i] = '0; bad[i] = 0; end
        exp_perr = 0;
    endtask

    task automatic do_recover(input int halt_wait, input bit noise, input int rst_at);
        logic [1:0]  ew;
        logic [11:0] ea;
        logic [63:0] ed;
        @(negedge clk);
        check("idle_ctl", {bus.core_halt_o, bus.recover_busy_o, bus.recover_done_o}, 0);
        bus.recover_req_i = 1'b1;
        if (noise) rand_cap(1); else drive_cap(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.recover_req_i = 1'b0;
        if (noise) rand_cap(1); else drive_cap(0, 0, 0, 0, 0, 0);
        check("halt_ctl", {bus.core_halt_o, bus.recover_busy_o,
                           bus.recover_done_o, |bus.rf_we_o}, 4'b1100);
        for (int w = 0; w < halt_wait; w++) begin
            @(negedge clk);
            drive_cap(0, 0, 0, 0, 0, 0);
            check("halt_wait", {bus.core_halt_o, bus.recover_busy_o,
                                |bus.rf_we_o}, 3'b110);
        end
        bus.core_halted_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ew = '0; ea = '0; ed = '0;
            for (int j = 0; j < 2; j++) begin
                int a;
                a = 1 + c * 2 + j;
                if (a <= 31) begin
                    ew[j] = 1'b1;
                    ea[j*6 +: 6] = 6'(a);
                    ed[j*32 +: 32] = m[a];
                    if (bad[a]) exp_perr = 1;
                end
            end
            check("rf_we", bus.rf_we_o, ew);
            check("rf_waddr", bus.rf_waddr_o, ea);
            check("rf_wdata", bus.rf_wdata_o, ed);
            check("rst_ctl", {bus.core_halt_o, bus.recover_busy_o,
                              bus.recover_done_o}, 3'b110);
            check("parity_err", bus.parity_err_o, exp_perr);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("midrst_out", {bus.core_halt_o, bus.recover_busy_o,
                    bus.recover_done_o, bus.parity_err_o, bus.rf_we_o}, 0);
                clear_model();
                bus.core_halted_i = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            bus.recover_req_i = noise && (c == 3);
            if (noise) rand_cap(0);
        end
        @(negedge clk);
        check("done_ctl", {bus.core_halt_o, bus.recover_done_o, |bus.rf_we_o}, 3'b110);
        bus.recover_req_i = 1'b0;
        bus.core_halted_i = 1'b0;
        drive_cap(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_ctl", {bus.core_halt_o, bus.recover_busy_o,
                           bus.recover_done_o, |bus.rf_we_o}, 0);
    endtask

    task automatic fp_recover();
        logic [2:0]  ew;
        logic [17:0] ea;
        logic [95:0] ed;
        for (int i = 0; i < 64; i++) m2[i] = '0;
        @(negedge clk);
        bus2.cap_we_i    = 2'b11;
        bus2.cap_waddr_i = {6'd63, 6'd40};
        bus2.cap_wdata_i = {32'hCAFE0063, 32'h3F800000};
        m2[40] = 32'h3F800000;
        m2[63] = 32'hCAFE0063;
        @(negedge clk);
        bus2.cap_we_i = '0;
        bus2.recover_req_i = 1'b1;
        @(negedge clk);
        bus2.recover_req_i = 1'b0;
        check("fp_halt", {bus2.core_halt_o, bus2.recover_busy_o, |bus2.rf_we_o}, 3'b110);
        bus2.core_halted_i = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            ew = '0; ea = '0; ed = '0;
            for (int j = 0; j < 3; j++) begin
                int a;
                a = 1 + c * 3 + j;
                if (a <= 63) begin
                    ew[j] = 1'b1;
                    ea[j*6 +: 6] = 6'(a);
                    ed[j*32 +: 32] = m2[a];
                end
            end
            check("fp_rf_we", bus2.rf_we_o, ew);
            check("fp_rf_waddr", bus2.rf_waddr_o, ea);
            check("fp_rf_wdata", bus2.rf_wdata_o, ed);
            check("fp_done_early", bus2.recover_done_o, 1'b0);
        end
        check("fp_last_addr", bus2.rf_waddr_o, {6'd63, 6'd62, 6'd61});
        @(negedge clk);
        bus2.core_halted_i = 1'b0;
        check("fp_done", {bus2.recover_done_o, |bus2.rf_we_o}, 2'b10);
        @(negedge clk);
        check("fp_idle", {bus2.core_halt_o, bus2.recover_done_o}, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.recover_req_i = 1'b0;
        bus.core_halted_i = 1'b0;
        bus2.recover_req_i = 1'b0;
        bus2.core_halted_i = 1'b0;
        bus2.cap_we_i = '0;
        bus2.cap_waddr_i = '0;
        bus2.cap_wdata_i = '0;
        drive_cap(0, 0, 0, 0, 0, 0);
        clear_model();
        repeat (2) @(negedge clk);
        check("reset_out", {bus.core_halt_o, bus.recover_busy_o, bus.recover_done_o,
            bus.parity_err_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o}, 0);
        check("reset_out2", {bus2.core_halt_o, bus2.recover_busy_o,
            bus2.recover_done_o, bus2.rf_we_o}, 0);
        rst = 1'b0;

        @(negedge clk);
        drive_cap(2'b11, 6'd5, 6'd31, 32'hDEADBEEF, 32'h12345678, 1);
        @(negedge clk);
        drive_cap(0, 0, 0, 0, 0, 0);
        do_recover(1, 0, -1);

        @(negedge clk);
        drive_cap(2'b11, 6'd7, 6'd7, 32'hAAAA0000, 32'h5555FFFF, 1);
        @(negedge clk);
        drive_cap(2'b01, 6'd0, 6'd0, 32'hFFFFFFFF, 32'h0, 1);
        check("x7_model", m[7], 32'h5555FFFF);
        do_recover(0, 0, -1);

        for (int r = 0; r < 3; r++) begin
            repeat (12) begin
                @(negedge clk);
                rand_cap(1);
            end
            do_recover(r, 1, -1);
        end

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        @(negedge clk);
        dut.r_shadow[9][3] = ~dut.r_shadow[9][3];
        m[9][3] = ~m[9][3];
        bad[9] = 1;
`endif
        do_recover(0, 0, -1);
        check("perr_sticky", bus.parity_err_o, exp_perr);

        do_recover(0, 0, 4);
        check("after_rst", {bus.core_halt_o, bus.recover_busy_o, bus.parity_err_o}, 0);
        do_recover(0, 0, -1);

        fp_recover();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
